// File: rtl/add80_word_sequencer.sv
// add80_word_sequencer
//
// Purpose:
//   Sequential front/back end for an external 80-bit combinational ripple-carry
//   adder. Two 80-bit operands and a carry-in are collected word by word over a
//   valid/ready input bus (A words then B words, LS word first). They are held
//   in registers that drive the adder directly. After SETTLE_CYC cycles the
//   adder Sum/Cout are captured, and the result is streamed back out word by
//   word (LS word first) over a valid/ready output bus.
//
// Parameters:
//   WORD_W      bus word width, must divide 80 (8, 10, 16, 20 or 40)
//   SETTLE_CYC  cycles allowed for the ripple carry to settle (>= 1)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block accepts an input word (LOAD_A / LOAD_B only)
//   in_data    operand word
//   in_cin     carry-in, sampled together with A word 0 only
//   add_a      registered operand A to the adder
//   add_b      registered operand B to the adder
//   add_cin    registered carry-in to the adder
//   add_sum    adder Sum
//   add_cout   adder carry-out of bit 79
//   out_valid  result word valid (EMIT only)
//   out_ready  downstream accepts the result word
//   out_data   result word
//   out_last   marks the final result word
//   out_cout   captured carry-out, valid whenever out_valid=1

module add80_word_sequencer #(
    parameter int unsigned WORD_W     = 20,
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_cin,

    output logic [79:0]       add_a,
    output logic [79:0]       add_b,
    output logic              add_cin,
    input  logic [79:0]       add_sum,
    input  logic              add_cout,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              out_cout
);

    localparam int unsigned WORDS = 80 / WORD_W;
    localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [KW-1:0] KLast = KW'(WORDS - 1);
    localparam logic [SW-1:0] SLast = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StSettle,
        StEmit
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] s_q, s_d;
    logic [79:0]   add_a_q, add_a_d;
    logic [79:0]   add_b_q, add_b_d;
    logic          add_cin_q, add_cin_d;
    logic [79:0]   result_q, result_d;
    logic          cout_q, cout_d;

    logic          in_hs;
    logic          out_hs;
    logic          k_at_last;
    int unsigned   word_lsb;

    // Bit offset of the word selected by k, shared by load and emit.
    assign word_lsb  = 32'(k_q) * WORD_W;
    assign k_at_last = (k_q == KLast);

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        s_d       = s_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        result_d  = result_q;
        cout_d    = cout_q;

        unique case (state_q)
            StLoadA: begin
                if (in_hs) begin
                    add_a_d[word_lsb +: WORD_W] = in_data;
                    if (k_q == '0) begin
                        add_cin_d = in_cin;
                    end
                    if (k_at_last) begin
                        state_d = StLoadB;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            StLoadB: begin
                if (in_hs) begin
                    add_b_d[word_lsb +: WORD_W] = in_data;
                    if (k_at_last) begin
                        state_d = StSettle;
                        k_d     = '0;
                        s_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            StSettle: begin
                // Operands have been stable since the last B word; the adder
                // output is trusted only on the final settle cycle.
                if (s_q == SLast) begin
                    result_d = add_sum;
                    cout_d   = add_cout;
                    state_d  = StEmit;
                    k_d      = '0;
                    s_d      = '0;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end

            StEmit: begin
                if (out_hs) begin
                    if (k_at_last) begin
                        state_d = StLoadA;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StLoadA;
                k_d     = '0;
                s_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoadA;
            k_q       <= '0;
            s_q       <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            s_q       <= s_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: handshake strobes decode from state only, so in_ready and
    // out_valid can never be high together. Result outputs read zero
    // outside EMIT.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_cout  = 1'b0;

        unique case (state_q)
            StLoadA, StLoadB: begin
                in_ready = 1'b1;
            end
            StEmit: begin
                out_valid = 1'b1;
                out_data  = result_q[word_lsb +: WORD_W];
                out_last  = k_at_last;
                out_cout  = cout_q;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    a_ready_valid_exclusive : assert property (
        @(posedge clk) !(in_ready && out_valid)
    );

    a_out_stable_on_stall : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_last) && $stable(out_cout))
    );

    a_operands_hold_outside_load : assert property (
        @(posedge clk) disable iff (rst)
        (state_q == StSettle || state_q == StEmit) |=>
            ($stable(add_a_q) && $stable(add_b_q) && $stable(add_cin_q))
    );

endmodule

// File: tb/tb_add80_word_sequencer.sv
// tb_add80_word_sequencer
//
// Bench for add80_word_sequencer with the default geometry (20-bit words,
// 4 words per operand, 2 settle cycles). The external adder is stood in for by
// a behavioural 81-bit sum that reads back inverted on the first cycle after
// its inputs change, so a result captured before the operands have settled
// shows up as wrong data. Expected results come from plain 81-bit arithmetic
// on the operands the bench itself sent.

module tb_add80_word_sequencer;

    localparam int W      = 20;
    localparam int WORDS  = 4;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_cin;
    logic [79:0]   add_a;
    logic [79:0]   add_b;
    logic          add_cin;
    logic [79:0]   add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add80_word_sequencer #(
        .WORD_W     (W),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_cout  (out_cout)
    );

    // Adder stand-in: true sum only once operands held for a full cycle.
    logic [160:0] adder_in_prev;
    logic [80:0]  true_sum;
    logic         adder_settled;

    assign true_sum      = {1'b0, add_a} + {1'b0, add_b} + {80'd0, add_cin};
    assign adder_settled = ({add_a, add_b, add_cin} == adder_in_prev);
    assign {add_cout, add_sum} = adder_settled ? true_sum : ~true_sum;

    always @(posedge clk) adder_in_prev <= {add_a, add_b, add_cin};

    // Reference model: plain modulo-2^80 addition with the carry kept apart.
    function automatic logic [80:0] ref_add(input logic [79:0] a, input logic [79:0] b,
                                            input logic c);
        return {1'b0, a} + {1'b0, b} + {80'd0, c};
    endfunction

    function automatic logic [79:0] rand80();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    // ------------------------------------------------------------------
    // Drivers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic send_word(input logic [W-1:0] d, input logic c, input int gap,
                             output bit ok);
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            in_cin   = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = c;
        for (int n = 0; n < 50; n++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Non-zero A words and all B words carry a random in_cin that must be ignored.
    task automatic load_op(input logic [79:0] a, input logic [79:0] b, input logic c,
                           input int max_gap, input int b_words, output bit ok);
        bit w_ok;
        ok = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            send_word(a[i*W +: W], (i == 0) ? c : 1'($urandom),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, w_ok);
            ok &= w_ok;
        end
        for (int i = 0; i < b_words; i++) begin
            send_word(b[i*W +: W], 1'($urandom),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0, w_ok);
            ok &= w_ok;
        end
    endtask

    // Waits for the result and drains it; stall_idx < 0 means no stall.
    task automatic collect(input int stall_idx, input int stall_len,
                           output logic [79:0] data, output logic [3:0] last,
                           output logic cout, output int lat, output int stall_bad,
                           output int settle_ir, output bit got_all,
                           output logic ready_after);
        data      = '0;
        last      = '0;
        cout      = 1'b0;
        lat       = 0;
        stall_bad = 0;
        settle_ir = 0;
        got_all   = 1'b1;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && lat < 50) begin
            if (in_ready !== 1'b0) settle_ir++;
            @(negedge clk);
            lat++;
        end
        for (int w = 0; w < WORDS; w++) begin
            if (out_valid !== 1'b1) begin
                got_all = 1'b0;
                break;
            end
            data[w*W +: W] = out_data;
            last[w]        = out_last;
            if (w == 0) cout = out_cout;
            else if (out_cout !== cout) stall_bad++;
            if (w == stall_idx) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_data !== data[w*W +: W] ||
                        out_last !== last[w] || out_cout !== cout || in_ready !== 1'b0)
                        stall_bad++;
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        ready_after = in_ready;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = W'($urandom);
            in_cin  = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_cout !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_outputs got valid=%b data=%h last=%b cout=%b want all 0",
                     out_valid, out_data, out_last, out_cout);
        end
        checks++;
        if (add_a !== '0 || add_b !== '0 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_operands got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (add_a !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_load got a=%h ready=%b want a=0 ready=1", add_a, in_ready);
        end
    endtask

    // Directed operation with fixed expected result.
    task automatic run_directed(input string name, input logic [79:0] a, input logic [79:0] b,
                                input logic c, input logic [79:0] want_sum,
                                input logic want_cout);
        bit ok, got_all;
        logic [79:0] data;
        logic [3:0] last;
        logic cout, ready_after;
        int lat, stall_bad, settle_ir;
        load_op(a, b, c, 0, WORDS, ok);
        collect(-1, 0, data, last, cout, lat, stall_bad, settle_ir, got_all, ready_after);
        checks++;
        if (!ok || !got_all) begin
            errors++; $display("FAIL %s_handshake got load_ok=%b drained=%b want 1", name, ok,
                               got_all);
        end
        checks++;
        if (data !== want_sum) begin
            errors++; $display("FAIL %s_sum got %h want %h", name, data, want_sum);
        end
        checks++;
        if (cout !== want_cout) begin
            errors++; $display("FAIL %s_cout got %b want %b", name, cout, want_cout);
        end
        checks++;
        if (last !== 4'b1000) begin
            errors++; $display("FAIL %s_last got %b want 1000", name, last);
        end
        checks++;
        if (lat !== SETTLE || settle_ir !== 0) begin
            errors++; $display("FAIL %s_latency got %0d (ready_hits %0d) want %0d (0)", name,
                               lat, settle_ir, SETTLE);
        end
        checks++;
        if (ready_after !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_return got ready=%b valid=%b want 1/0", name,
                               ready_after, out_valid);
        end
    endtask

    task automatic test_simple_add();
        run_directed("simple", 80'h1, 80'h1, 1'b0, 80'h2, 1'b0);
    endtask

    task automatic test_full_propagation();
        run_directed("full_prop_b1", {80{1'b1}}, 80'h1, 1'b0, 80'h0, 1'b1);
        run_directed("full_prop_cin", {80{1'b1}}, 80'h0, 1'b1, 80'h0, 1'b1);
    endtask

    task automatic test_boundary_carry();
        run_directed("boundary40", 80'h00000_00000_FFFFF_FFFFF, 80'h0, 1'b1,
                     80'h00000_00001_00000_00000, 1'b0);
    endtask

    task automatic test_input_gaps();
        for (int it = 0; it < 4; it++) begin
            logic [79:0] a, b, data;
            logic [80:0] exp;
            logic c, cout, ready_after;
            logic [3:0] last;
            bit ok, got_all;
            int lat, stall_bad, settle_ir;
            a = rand80(); b = rand80(); c = 1'($urandom);
            exp = ref_add(a, b, c);
            load_op(a, b, c, 3, WORDS, ok);
            checks++;
            if (!ok || add_a !== a || add_b !== b || add_cin !== c) begin
                errors++;
                $display("FAIL gaps_operands it%0d got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                         it, add_a, add_b, add_cin, a, b, c);
            end
            collect(-1, 0, data, last, cout, lat, stall_bad, settle_ir, got_all, ready_after);
            checks++;
            if (!got_all || data !== exp[79:0] || cout !== exp[80]) begin
                errors++;
                $display("FAIL gaps_result it%0d got %b:%h want %b:%h", it, cout, data,
                         exp[80], exp[79:0]);
            end
        end
    endtask

    task automatic test_output_stall();
        logic [79:0] a, b, data;
        logic [80:0] exp;
        logic c, cout, ready_after;
        logic [3:0] last;
        bit ok, got_all;
        int lat, stall_bad, settle_ir;
        a = rand80(); b = rand80(); c = 1'b1;
        exp = ref_add(a, b, c);
        load_op(a, b, c, 0, WORDS, ok);
        collect(2, 5, data, last, cout, lat, stall_bad, settle_ir, got_all, ready_after);
        checks++;
        if (stall_bad !== 0) begin
            errors++; $display("FAIL stall_stable got %0d bad cycles want 0", stall_bad);
        end
        checks++;
        if (!ok || !got_all || data !== exp[79:0] || cout !== exp[80] || last !== 4'b1000)
        begin
            errors++;
            $display("FAIL stall_result got %b:%h last=%b want %b:%h last=1000", cout, data,
                     last, exp[80], exp[79:0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            logic [79:0] a, b, data;
            logic [80:0] exp;
            logic c, cout, ready_after;
            logic [3:0] last;
            bit ok, got_all;
            int lat, stall_bad, settle_ir;
            a = rand80(); b = rand80(); c = it[0];
            if (it == 3) b = ~a;
            exp = ref_add(a, b, c);
            load_op(a, b, c, 0, WORDS, ok);
            collect(-1, 0, data, last, cout, lat, stall_bad, settle_ir, got_all, ready_after);
            checks++;
            if (!ok || !got_all || data !== exp[79:0] || cout !== exp[80] ||
                ready_after !== 1'b1) begin
                errors++;
                $display("FAIL b2b_result it%0d got %b:%h ready=%b want %b:%h ready=1", it,
                         cout, data, ready_after, exp[80], exp[79:0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        load_op(rand80(), rand80(), 1'b1, 0, 2, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (!ok || add_a !== '0 || add_b !== '0 || add_cin !== 1'b0 || in_ready !== 1'b1 ||
            out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear got a=%h b=%h cin=%b ready=%b valid=%b want 0s/1/0",
                     add_a, add_b, add_cin, in_ready, out_valid);
        end
        run_directed("midreset_run", 80'h3, 80'h5, 1'b1, 80'h9, 1'b0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        test_reset();
        test_simple_add();
        test_full_propagation();
        test_boundary_carry();
        test_input_gaps();
        test_output_stall();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
